// File: rtl/grey_pkg.sv
// Shared constants and types for the Johnson-coded digit display path.
// Holds code points, segment patterns and the scan FSM state type.
package grey_pkg;

    localparam int unsigned DIG_W      = 5;
    localparam int unsigned NUM_DIGITS = 12;

    localparam logic [DIG_W-1:0] JC_0 = 5'b00000;
    localparam logic [DIG_W-1:0] JC_1 = 5'b00001;
    localparam logic [DIG_W-1:0] JC_2 = 5'b00011;
    localparam logic [DIG_W-1:0] JC_3 = 5'b00111;
    localparam logic [DIG_W-1:0] JC_4 = 5'b01111;
    localparam logic [DIG_W-1:0] JC_5 = 5'b11111;
    localparam logic [DIG_W-1:0] JC_6 = 5'b11110;
    localparam logic [DIG_W-1:0] JC_7 = 5'b11100;
    localparam logic [DIG_W-1:0] JC_8 = 5'b11000;
    localparam logic [DIG_W-1:0] JC_9 = 5'b10000;

    // Segment order is {g,f,e,d,c,b,a}, active-high
    localparam logic [6:0] SEG_0    = 7'h3F;
    localparam logic [6:0] SEG_1    = 7'h06;
    localparam logic [6:0] SEG_2    = 7'h5B;
    localparam logic [6:0] SEG_3    = 7'h4F;
    localparam logic [6:0] SEG_4    = 7'h66;
    localparam logic [6:0] SEG_5    = 7'h6D;
    localparam logic [6:0] SEG_6    = 7'h7D;
    localparam logic [6:0] SEG_7    = 7'h07;
    localparam logic [6:0] SEG_8    = 7'h7F;
    localparam logic [6:0] SEG_9    = 7'h6F;
    localparam logic [6:0] SEG_DASH = 7'h40;
    localparam logic [6:0] SEG_OFF  = 7'h00;

    typedef enum logic [1:0] {
        LOAD,
        SHOW,
        BLANK
    } state_t;

endpackage

// File: rtl/johnson_seg7.sv
// Combinational decode of one 5-bit Johnson digit into validity, zero flag
// and a seven-segment pattern; invalid codes render as a dash.
module johnson_seg7
    import grey_pkg::*;
(
    input  logic [DIG_W-1:0] i_code,
    output logic             o_valid,
    output logic             o_zero,
    output logic [6:0]       o_seg
);

    always_comb begin
        o_valid = 1'b1;
        o_zero  = 1'b0;
        o_seg   = SEG_DASH;
        case (i_code)
            JC_0: begin o_seg = SEG_0; o_zero = 1'b1; end
            JC_1: o_seg = SEG_1;
            JC_2: o_seg = SEG_2;
            JC_3: o_seg = SEG_3;
            JC_4: o_seg = SEG_4;
            JC_5: o_seg = SEG_5;
            JC_6: o_seg = SEG_6;
            JC_7: o_seg = SEG_7;
            JC_8: o_seg = SEG_8;
            JC_9: o_seg = SEG_9;
            default: o_valid = 1'b0;
        endcase
    end

endmodule

// File: rtl/johnson_scan7.sv
// Frame-snapshot, MSD-first multiplexed seven-segment driver for a
// 12-digit Johnson-coded counter, with blanking, dp, hold and error flag.
module johnson_scan7
    import grey_pkg::*;
#(
    parameter int unsigned DIGITS    = NUM_DIGITS,
    parameter int unsigned DWELL     = 1000,
    parameter int unsigned BLANK_CYC = 2
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic [DIGITS*DIG_W-1:0] i_digits,
    input  logic                    i_en,
    input  logic                    i_hold,
    input  logic                    i_lzb,
    input  logic [3:0]              i_dp_pos,
    output logic [7:0]              o_seg,
    output logic [3:0]              o_dig,
    output logic                    o_frame,
    output logic                    o_err
);

    localparam int unsigned MAXC = (DWELL > BLANK_CYC) ? DWELL : BLANK_CYC;
    localparam int unsigned CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
    localparam logic [3:0]    LAST      = 4'(DIGITS - 1);
    localparam logic [CW-1:0] DWELL_END = CW'(DWELL - 1);
    localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYC - 1);

    state_t                  r_state, w_nxt_state;
    logic [CW-1:0]           r_cnt, w_nxt_cnt;
    logic [3:0]              r_idx, w_nxt_idx;
    logic                    r_seen, w_nxt_seen;
    logic [DIGITS*DIG_W-1:0] r_snap, w_snap_nxt;
    logic [7:0]              r_seg, w_nxt_seg;
    logic [3:0]              r_dig, w_nxt_dig;
    logic                    r_frame, w_nxt_frame;
    logic                    r_err, w_nxt_err;

    logic [DIGITS-1:0] w_valid;
    logic [DIGITS-1:0] w_zero;
    logic [6:0]        w_seg7 [DIGITS];
    logic              w_show;
    logic              w_seen_in;
    logic [3:0]        w_show_idx;
    logic              w_blank;

    // Outputs are registered from next-state values, so the digit shown right
    // after LOAD must come from the snapshot being captured on that same edge.
    assign w_snap_nxt = (r_state == LOAD && i_en && !i_hold) ? i_digits : r_snap;

    for (genvar k = 0; k < DIGITS; k++) begin : g_dec
        johnson_seg7 u_dec (
            .i_code  (w_snap_nxt[k*DIG_W +: DIG_W]),
            .o_valid (w_valid[k]),
            .o_zero  (w_zero[k]),
            .o_seg   (w_seg7[k])
        );
    end

    always_comb begin
        w_nxt_state = r_state;
        w_nxt_cnt   = r_cnt;
        w_nxt_idx   = r_idx;
        w_nxt_seen  = r_seen;
        w_nxt_seg   = '0;
        w_nxt_dig   = r_dig;
        w_nxt_err   = r_err;
        w_show      = 1'b0;
        w_show_idx  = r_idx;
        w_seen_in   = r_seen;
        w_blank     = 1'b0;

        if (!i_en) begin
            w_nxt_state = LOAD;
            w_nxt_cnt   = '0;
            w_nxt_idx   = LAST;
            w_nxt_seen  = 1'b0;
            w_nxt_dig   = LAST;
        end else begin
            case (r_state)
                LOAD: begin
                    w_nxt_state = SHOW;
                    w_nxt_cnt   = '0;
                    w_nxt_idx   = LAST;
                    w_nxt_err   = ~&w_valid;
                    w_show      = 1'b1;
                    w_show_idx  = LAST;
                    w_seen_in   = 1'b0;
                end
                SHOW: begin
                    if (r_cnt == DWELL_END) begin
                        w_nxt_state = BLANK;
                        w_nxt_cnt   = '0;
                    end else begin
                        w_nxt_cnt = r_cnt + 1'b1;
                        w_show    = 1'b1;
                    end
                end
                BLANK: begin
                    if (r_cnt == BLANK_END) begin
                        w_nxt_cnt = '0;
                        if (r_idx == 4'd0) begin
                            w_nxt_state = LOAD;
                            w_nxt_idx   = LAST;
                            w_nxt_seen  = 1'b0;
                            w_nxt_dig   = LAST;
                        end else begin
                            w_nxt_state = SHOW;
                            w_nxt_idx   = r_idx - 1'b1;
                            w_show      = 1'b1;
                            w_show_idx  = r_idx - 1'b1;
                        end
                    end else begin
                        w_nxt_cnt = r_cnt + 1'b1;
                    end
                end
                default: w_nxt_state = LOAD;
            endcase
        end

        if (w_show) begin
            w_blank    = i_lzb && !w_seen_in && w_zero[w_show_idx] && (w_show_idx != 4'd0);
            w_nxt_dig  = w_show_idx;
            w_nxt_seg  = {(w_show_idx == i_dp_pos), (w_blank ? SEG_OFF : w_seg7[w_show_idx])};
            w_nxt_seen = w_seen_in | ~w_zero[w_show_idx];
        end

        w_nxt_frame = (w_nxt_state == LOAD);
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_state <= LOAD;
            r_cnt   <= '0;
            r_idx   <= LAST;
            r_seen  <= 1'b0;
            r_snap  <= '0;
            r_seg   <= '0;
            r_dig   <= LAST;
            r_frame <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_nxt_state;
            r_cnt   <= w_nxt_cnt;
            r_idx   <= w_nxt_idx;
            r_seen  <= w_nxt_seen;
            r_snap  <= w_snap_nxt;
            r_seg   <= w_nxt_seg;
            r_dig   <= w_nxt_dig;
            r_frame <= w_nxt_frame;
            r_err   <= w_nxt_err;
        end
    end

    // Live i_en gating blanks the display in the very cycle enable drops and
    // suppresses the frame pulse while parked in LOAD.
    assign o_seg   = i_en ? r_seg : '0;
    assign o_frame = r_frame & i_en;
    assign o_dig   = r_dig;
    assign o_err   = r_err;

endmodule
